// File: rtl/chi_pkg.sv
// CHI REQ channel types shared by the HN-F link-layer receivers:
// request flit layout, ReqLCrdReturn opcode and link-state encoding.
package chi_pkg;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgtid;
    logic [6:0]  srcid;
    logic [7:0]  txnid;
    logic [5:0]  opcode;
    logic [47:0] addr;
  } reqflit_t;

  localparam logic [5:0] REQ_LCRDRET = 6'h00;

  typedef enum logic [1:0] {
    STOP,
    ACTIVATE,
    RUN,
    DEACTIVATE
  } link_state_e;

endpackage

// File: rtl/hnf_posq_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Ports: clock, reset, push/din, pop/dout/valid, count.
module hnf_posq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/hnf_rxreq_lcrd.sv
// HN-F RXREQ link receiver: link activation, L-credit issue/return, POSQ.
// Ports: link req/ack, flit in, lcrdv out, POSQ head handshake, status.
// Optional HNF_RXREQ_TGTID_CHK_EN adds TgtID filter (err_tgtid, tgtid_drop_cnt).
module hnf_rxreq_lcrd
  import chi_pkg::*;
#(
  parameter int         POSQ_DEPTH     = 8,
  parameter int         MAX_LCRD       = 15,
  parameter logic [6:0] HN_ID          = 7'h00,
  parameter logic [5:0] LCRDRET_OPCODE = REQ_LCRDRET
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              rxlinkactivereq,
  output logic                              rxlinkactiveack,
  input  logic                              rxreqflitpend,
  input  logic                              rxreqflitv,
  input  reqflit_t                          rxreqflit,
  output logic                              rxreqlcrdv,
  output reqflit_t                          posq_head,
  output logic                              posq_head_v,
  input  logic                              posq_head_rdy,
  output logic [$clog2(POSQ_DEPTH+1)-1:0]   posq_count,
  output logic [3:0]                        lcrd_out,
  output logic                              err_nocrd
`ifdef HNF_RXREQ_TGTID_CHK_EN
  ,
  output logic                              err_tgtid,
  output logic [7:0]                        tgtid_drop_cnt
`endif
);

  link_state_e state;
  link_state_e state_n;

  logic       has_crd;
  logic       consume;
  logic       is_ret;
  logic       tgt_ok;
  logic       enq;
  logic       issue;
  logic [7:0] crd_sum;
  logic       unused_pend;

  // The pending hint carries no functional meaning here.
  assign unused_pend = rxreqflitpend;

  assign has_crd = (lcrd_out != 4'd0);
  assign consume = rxreqflitv && has_crd;
  assign is_ret  = (rxreqflit.opcode == LCRDRET_OPCODE);

`ifdef HNF_RXREQ_TGTID_CHK_EN
  assign tgt_ok = (rxreqflit.tgtid == HN_ID);
`else
  assign tgt_ok = 1'b1;
`endif

  assign enq = consume && !is_ret && tgt_ok;

  // Credits in flight plus buffered entries must fit in the POSQ;
  // a same-cycle pop is ignored, so this never over-commits.
  assign crd_sum = 8'(lcrd_out) + 8'(posq_count);
  assign issue   = (state == RUN)
                && (lcrd_out < 4'(MAX_LCRD))
                && (crd_sum < 8'(POSQ_DEPTH));

  always_comb begin
    state_n         = state;
    rxlinkactiveack = 1'b1;
    unique case (state)
      STOP: begin
        rxlinkactiveack = 1'b0;
        if (rxlinkactivereq) state_n = ACTIVATE;
      end
      ACTIVATE: state_n = RUN;
      RUN: if (!rxlinkactivereq) state_n = DEACTIVATE;
      DEACTIVATE: if (!has_crd && !rxreqflitv) state_n = STOP;
      default: state_n = STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= STOP;
      rxreqlcrdv <= 1'b0;
      lcrd_out   <= 4'd0;
      err_nocrd  <= 1'b0;
    end else begin
      state      <= state_n;
      rxreqlcrdv <= issue;
      unique case ({issue, consume})
        2'b10:   lcrd_out <= lcrd_out + 4'd1;
        2'b01:   lcrd_out <= lcrd_out - 4'd1;
        default: lcrd_out <= lcrd_out;
      endcase
      if (rxreqflitv && !has_crd) err_nocrd <= 1'b1;
    end
  end

`ifdef HNF_RXREQ_TGTID_CHK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_tgtid      <= 1'b0;
      tgtid_drop_cnt <= 8'd0;
    end else if (consume && !is_ret && !tgt_ok) begin
      err_tgtid <= 1'b1;
      if (tgtid_drop_cnt != 8'hFF)
        tgtid_drop_cnt <= tgtid_drop_cnt + 8'd1;
    end
  end
`endif

  hnf_posq_fifo #(
    .WIDTH ($bits(reqflit_t)),
    .DEPTH (POSQ_DEPTH)
  ) u_posq (
    .clock (clock),
    .reset (reset),
    .push  (enq),
    .din   (rxreqflit),
    .pop   (posq_head_rdy),
    .dout  (posq_head),
    .valid (posq_head_v),
    .count (posq_count)
  );

  a_lcrd_nowrap: assert property (
    @(posedge clock) disable iff (reset)
    !(issue && !consume && lcrd_out == 4'hF));

endmodule

// File: tb/tb_hnf_rxreq_lcrd.sv
// Directed bench for hnf_rxreq_lcrd: activation, fill/drain,
// streaming, credit return, no-credit error and optional TgtID filter.
module tb_hnf_rxreq_lcrd;
  import chi_pkg::*;

  localparam logic [6:0] HN = 7'h04;
  localparam logic [5:0] RD = 6'h04;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxlinkactivereq;
  logic       rxlinkactiveack;
  logic       rxreqflitpend;
  logic       rxreqflitv;
  reqflit_t   rxreqflit;
  logic       rxreqlcrdv;
  reqflit_t   posq_head;
  logic       posq_head_v;
  logic       posq_head_rdy;
  logic [3:0] posq_count;
  logic [3:0] lcrd_out;
  logic       err_nocrd;
`ifdef HNF_RXREQ_TGTID_CHK_EN
  logic       err_tgtid;
  logic [7:0] tgtid_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int model  = 0;

  always #5 clock = ~clock;

  hnf_rxreq_lcrd #(
    .POSQ_DEPTH (8),
    .MAX_LCRD   (15),
    .HN_ID      (HN)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rxlinkactivereq (rxlinkactivereq),
    .rxlinkactiveack (rxlinkactiveack),
    .rxreqflitpend   (rxreqflitpend),
    .rxreqflitv      (rxreqflitv),
    .rxreqflit       (rxreqflit),
    .rxreqlcrdv      (rxreqlcrdv),
    .posq_head       (posq_head),
    .posq_head_v     (posq_head_v),
    .posq_head_rdy   (posq_head_rdy),
    .posq_count      (posq_count),
    .lcrd_out        (lcrd_out),
    .err_nocrd       (err_nocrd)
`ifdef HNF_RXREQ_TGTID_CHK_EN
    ,
    .err_tgtid       (err_tgtid),
    .tgtid_drop_cnt  (tgtid_drop_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
    if (rxreqlcrdv) begin
      pulses++;
      model++;
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [7:0] txn,
                      input logic [6:0] tgt);
    rxreqflit        = '0;
    rxreqflit.opcode = op;
    rxreqflit.txnid  = txn;
    rxreqflit.tgtid  = tgt;
    rxreqflit.addr   = {40'h0, txn};
    rxreqflitv       = 1'b1;
    rxreqflitpend    = 1'b1;
    step();
    rxreqflitv    = 1'b0;
    rxreqflitpend = 1'b0;
    model--;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    rxlinkactivereq = 1'b0;
    rxreqflitv      = 1'b0;
    rxreqflitpend   = 1'b0;
    rxreqflit       = '0;
    posq_head_rdy   = 1'b0;
    step();
    step();
    reset  = 1'b0;
    pulses = 0;
    model  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (rxlinkactiveack !== 1'b0) begin
      errors++; $display("FAIL reset_ack got %0d want 0", rxlinkactiveack);
    end
    if (rxreqlcrdv !== 1'b0) begin
      errors++; $display("FAIL reset_lcrdv got %0d want 0", rxreqlcrdv);
    end
    if (posq_head_v !== 1'b0) begin
      errors++; $display("FAIL reset_head_v got %0d want 0", posq_head_v);
    end
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", posq_count);
    end
    if (lcrd_out !== 4'd0) begin
      errors++; $display("FAIL reset_lcrd got %0d want 0", lcrd_out);
    end
    if (err_nocrd !== 1'b0) begin
      errors++; $display("FAIL reset_err got %0d want 0", err_nocrd);
    end
  endtask

  task automatic test_nocrd();
    send(RD, 8'hEE, HN);
    model++;
    checks += 2;
    if (err_nocrd !== 1'b1) begin
      errors++; $display("FAIL nocrd_err got %0d want 1", err_nocrd);
    end
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL nocrd_count got %0d want 0", posq_count);
    end
    step();
    checks += 2;
    if (posq_head_v !== 1'b0) begin
      errors++; $display("FAIL nocrd_head_v got %0d want 0", posq_head_v);
    end
    if (err_nocrd !== 1'b1) begin
      errors++; $display("FAIL nocrd_sticky got %0d want 1", err_nocrd);
    end
    do_reset();
    checks++;
    if (err_nocrd !== 1'b0) begin
      errors++; $display("FAIL nocrd_clear got %0d want 0", err_nocrd);
    end
  endtask

  task automatic test_activation();
    rxlinkactivereq = 1'b1;
    step();
    checks += 2;
    if (rxlinkactiveack !== 1'b1) begin
      errors++; $display("FAIL act_ack got %0d want 1", rxlinkactiveack);
    end
    if (rxreqlcrdv !== 1'b0) begin
      errors++; $display("FAIL act_early_lcrdv got %0d want 0", rxreqlcrdv);
    end
    repeat (15) step();
    checks += 3;
    if (pulses != 8) begin
      errors++; $display("FAIL act_pulses got %0d want 8", pulses);
    end
    if (lcrd_out !== 4'd8) begin
      errors++; $display("FAIL act_lcrd got %0d want 8", lcrd_out);
    end
    if (rxreqlcrdv !== 1'b0) begin
      errors++; $display("FAIL act_idle_lcrdv got %0d want 0", rxreqlcrdv);
    end
  endtask

  task automatic test_fill_drain();
    int p0;
    int bad;
    for (int i = 0; i < 8; i++) send(RD, 8'h10 + 8'(i), HN);
    step();
    checks += 4;
    if (posq_count !== 4'd8) begin
      errors++; $display("FAIL fill_count got %0d want 8", posq_count);
    end
    if (lcrd_out !== 4'd0) begin
      errors++; $display("FAIL fill_lcrd got %0d want 0", lcrd_out);
    end
    if (posq_head_v !== 1'b1) begin
      errors++; $display("FAIL fill_head_v got %0d want 1", posq_head_v);
    end
    if (posq_head.txnid !== 8'h10) begin
      errors++; $display("FAIL fill_head got %0h want 10", posq_head.txnid);
    end
    p0 = pulses;
    posq_head_rdy = 1'b1;
    step();
    posq_head_rdy = 1'b0;
    repeat (3) step();
    checks += 3;
    if (pulses - p0 != 1) begin
      errors++; $display("FAIL pop_pulses got %0d want 1", pulses - p0);
    end
    if (lcrd_out !== 4'd1) begin
      errors++; $display("FAIL pop_lcrd got %0d want 1", lcrd_out);
    end
    if (posq_count !== 4'd7) begin
      errors++; $display("FAIL pop_count got %0d want 7", posq_count);
    end
    bad = 0;
    posq_head_rdy = 1'b1;
    for (int i = 1; i < 8; i++) begin
      if (!posq_head_v || posq_head.txnid !== 8'h10 + 8'(i)) bad++;
      step();
    end
    posq_head_rdy = 1'b0;
    repeat (4) step();
    checks += 4;
    if (bad != 0) begin
      errors++; $display("FAIL drain_order got %0d bad want 0", bad);
    end
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL drain_count got %0d want 0", posq_count);
    end
    if (lcrd_out !== 4'd8) begin
      errors++; $display("FAIL drain_lcrd got %0d want 8", lcrd_out);
    end
    if (int'(lcrd_out) != model) begin
      errors++; $display("FAIL drain_model got %0d want %0d", lcrd_out, model);
    end
  endtask

  task automatic test_back_to_back();
    int rd;
    int bad_ord;
    int bad_crd;
    rd = 0;
    bad_ord = 0;
    bad_crd = 0;
    posq_head_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (posq_head_v) begin
        if (posq_head.txnid !== 8'h80 + 8'(rd)) bad_ord++;
        rd++;
      end
      send(RD, 8'h80 + 8'(i), HN);
      if (i >= 1 && lcrd_out !== 4'd6) bad_crd++;
    end
    repeat (4) begin
      if (posq_head_v) begin
        if (posq_head.txnid !== 8'h80 + 8'(rd)) bad_ord++;
        rd++;
      end
      step();
    end
    posq_head_rdy = 1'b0;
    checks += 6;
    if (bad_crd != 0) begin
      errors++; $display("FAIL b2b_lcrd_const got %0d bad want 0", bad_crd);
    end
    if (bad_ord != 0 || rd != 20) begin
      errors++; $display("FAIL b2b_order got %0d popped want 20", rd);
    end
    if (err_nocrd !== 1'b0) begin
      errors++; $display("FAIL b2b_err got %0d want 0", err_nocrd);
    end
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL b2b_count got %0d want 0", posq_count);
    end
    if (lcrd_out !== 4'd8) begin
      errors++; $display("FAIL b2b_lcrd_end got %0d want 8", lcrd_out);
    end
    if (int'(lcrd_out) != model) begin
      errors++; $display("FAIL b2b_model got %0d want %0d", lcrd_out, model);
    end
  endtask

  task automatic test_credit_return();
    int bad;
    int p0;
    for (int i = 0; i < 3; i++) send(RD, 8'h40 + 8'(i), HN);
    checks++;
    if (lcrd_out !== 4'd5) begin
      errors++; $display("FAIL ret_start got %0d want 5", lcrd_out);
    end
    p0 = pulses;
    rxlinkactivereq = 1'b0;
    step();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      send(REQ_LCRDRET, 8'hA0, HN);
      if (lcrd_out !== 4'(4 - k) || posq_count !== 4'd3) bad++;
    end
    checks += 3;
    if (bad != 0) begin
      errors++; $display("FAIL ret_count got %0d bad want 0", bad);
    end
    if (rxlinkactiveack !== 1'b1) begin
      errors++; $display("FAIL ret_ack_hold got %0d want 1", rxlinkactiveack);
    end
    if (pulses != p0) begin
      errors++; $display("FAIL ret_no_issue got %0d want %0d", pulses, p0);
    end
    step();
    checks++;
    if (rxlinkactiveack !== 1'b0) begin
      errors++; $display("FAIL ret_ack_drop got %0d want 0", rxlinkactiveack);
    end
    posq_head_rdy = 1'b1;
    repeat (3) step();
    posq_head_rdy = 1'b0;
    step();
    checks += 2;
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL ret_drain got %0d want 0", posq_count);
    end
    if (rxreqlcrdv !== 1'b0) begin
      errors++; $display("FAIL ret_stop_lcrdv got %0d want 0", rxreqlcrdv);
    end
  endtask

`ifdef HNF_RXREQ_TGTID_CHK_EN
  task automatic test_tgtid();
    rxlinkactivereq = 1'b1;
    repeat (14) step();
    send(RD, 8'h55, 7'h05);
    checks += 4;
    if (err_tgtid !== 1'b1) begin
      errors++; $display("FAIL tgt_err got %0d want 1", err_tgtid);
    end
    if (tgtid_drop_cnt !== 8'd1) begin
      errors++; $display("FAIL tgt_cnt got %0d want 1", tgtid_drop_cnt);
    end
    if (posq_count !== 4'd0) begin
      errors++; $display("FAIL tgt_count got %0d want 0", posq_count);
    end
    if (lcrd_out !== 4'd7) begin
      errors++; $display("FAIL tgt_lcrd got %0d want 7", lcrd_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nocrd();
    test_activation();
    test_fill_drain();
    test_back_to_back();
    test_credit_return();
`ifdef HNF_RXREQ_TGTID_CHK_EN
    test_tgtid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hnf_rxreq_lcrd.md
Name: hnf_rxreq_lcrd

Overview:
- HN-F RXREQ link-layer receiver with full CHI link-credit management and link activation handshake.
- Issues L-credits against free POSQ space, accepts request flits, absorbs ReqLCrdReturn flits, buffers requests in a parametrised POSQ and presents the head entry with a valid/ready handshake.
- Sits between the RN-F facing RXREQ channel and the HN-F request scheduler/pipeline.

Parameters:
- POSQ_DEPTH, 8, POSQ entries; 2..64.
- MAX_LCRD, 15, maximum outstanding L-credits (CHI limit); 1..15.
- HN_ID, 7'h00, this HN-F node ID used for TgtID checking.
- LCRDRET_OPCODE, 6'h00, REQ opcode identifying ReqLCrdReturn.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rxlinkactivereq  in  1  link activation request from the transmitter.
- rxlinkactiveack  out  1  link activation acknowledge.
- rxreqflitpend  in  1  flit-pending hint; advisory only.
- rxreqflitv  in  1  flit valid.
- rxreqflit  in  $bits(reqflit_t)  request flit.
- rxreqlcrdv  out  1  one L-credit granted per cycle high.
- posq_head  out  $bits(reqflit_t)  oldest buffered request.
- posq_head_v  out  1  posq_head is valid.
- posq_head_rdy  in  1  consumer pops head when posq_head_v & rdy.
- posq_count  out  $clog2(POSQ_DEPTH+1)  current occupancy.
- lcrd_out  out  4  L-credits currently held by the transmitter.
- err_nocrd  out  1  sticky: flit received with lcrd_out==0.

Behaviour:
- Reset values: rxlinkactiveack=0, rxreqlcrdv=0, posq_head_v=0, posq_count=0, lcrd_out=0, err_nocrd=0, FSM=STOP. posq_head contents are don't-care while posq_head_v=0.
- Reset mid-operation flushes the POSQ and credits without any return handshake.
- Link FSM transitions:
  - STOP -> ACTIVATE when rxlinkactivereq=1.
  - ACTIVATE -> RUN after one cycle; rxlinkactiveack=1 from ACTIVATE onward.
  - RUN -> DEACTIVATE when rxlinkactivereq=0.
  - DEACTIVATE -> STOP when lcrd_out==0 and no flit is arriving that cycle; ack drops on entering STOP.
  - If req reasserts in DEACTIVATE, stay in DEACTIVATE until STOP is reached; a new activation begins from STOP.
- Credit issue (registered output): rxreqlcrdv=1 next cycle iff all hold: FSM==RUN, lcrd_out < MAX_LCRD, lcrd_out + posq_count < POSQ_DEPTH. At most one credit per cycle. Dequeues in the same cycle are not counted; the check is conservative.
- Flit accept: on any cycle with rxreqflitv=1 and lcrd_out>0, one credit is consumed.
  - If Opcode==LCRDRET_OPCODE, the flit is discarded.
  - Otherwise it is enqueued.
- Flit with lcrd_out==0: dropped, err_nocrd set (sticky until reset).
- Credit counter: lcrd_out_next = lcrd_out + issue - consume. Simultaneous issue and consume leaves it unchanged. It never wraps; an assertion fires if it would.
- POSQ: first-word-fall-through. A flit enqueued in cycle N gives posq_head_v=1 in N+1. Simultaneous enqueue and dequeue when full is legal; the credit rule guarantees enqueue never occurs with POSQ full. An assertion checks this.
- Flits may arrive in STOP/ACTIVATE only if credits are outstanding, which is impossible after reset; such a flit is treated as a no-credit error.
- rxreqflitpend is ignored functionally; accept is based on rxreqflitv only.

Optional Feature:
- Macro HNF_RXREQ_TGTID_CHK_EN.
- Defined:
  - Non-return flits with TgtID != HN_ID still consume a credit but are dropped, not enqueued.
  - Adds output err_tgtid (1, sticky) and tgtid_drop_cnt (8, saturating counter).
- Undefined: no TgtID check, no extra ports; all non-return flits are enqueued.

Decomposition:
- chi_pkg holds reqflit_t, LCRDRET opcode constant, and the link-state enum (STOP/ACTIVATE/RUN/DEACTIVATE).
- Sub-module hnf_posq_fifo: parametrised WIDTH/DEPTH FWFT FIFO with count output, reusable by the other RX channels.

Test Plan:
- Activation with POSQ_DEPTH=8, MAX_LCRD=15:
  - Stimulus: raise rxlinkactivereq; hold; no flits.
  - Response: ack in 1 cycle; exactly 8 lcrdv pulses; lcrd_out=8; no further credits.
- Fill and drain:
  - Stimulus: send 8 requests; hold posq_head_rdy=0; then pop one.
  - Response: posq_count=8, lcrd_out=0; after the pop, one new lcrdv; head order matches send order.
- Credit return:
  - Stimulus: drop rxlinkactivereq while holding 5 credits; send 5 ReqLCrdReturn flits.
  - Response: no enqueue; lcrd_out counts 5->0; ack deasserts the cycle after the last return.
- Simultaneous issue and consume:
  - Stimulus: steady stream of one flit per cycle with the consumer always ready.
  - Response: lcrd_out constant; no overflow; no errors.
- No-credit violation:
  - Stimulus: rxreqflitv=1 right after reset.
  - Response: err_nocrd=1; posq_count stays 0.
- With HNF_RXREQ_TGTID_CHK_EN and HN_ID=7'h04:
  - Stimulus: a flit with TgtID=7'h05.
  - Response: dropped; err_tgtid=1; tgtid_drop_cnt=1; credit consumed.
